// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SIMPLE-group shifter (SLL, SLR, SRL, SRA).
// Moves at most STEP bit positions per clock. Produces a registered result
// and {S, Z, C, V} condition flags.
//
// Optional feature macro: ITER_SHIFTER_ROTATE_EN
//   defined   -> op=9 is rotate-left (SLR) with C=0
//   undefined -> rotate logic is absent; op=9 behaves exactly as SLL
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     block can accept (high only in IDLE)
//   op[3:0]      8=SLL, 9=SLR, 10=SRL, anything else=SRA
//   data[W-1:0]  operand (signed for SRA)
//   amt[A-1:0]   shift distance 0..WIDTH-1
//   out_valid    result/cond valid (high only in DONE)
//   out_ready    consumer accepts result
//   result[W-1:0] shifted value (0 outside DONE)
//   cond[3:0]    {S, Z, C, V} (0 outside DONE)
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready may be driven independently of valid. On the input side payload is
// sampled only at the accept edge; on the output side result/cond are held
// stable while out_valid=1 and out_ready=0.

module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cond,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Step width is one bit wider than amt so STEP==WIDTH still fits.
  localparam logic [AMT_W:0]   C_WIDTH = (AMT_W+1)'(WIDTH);
  localparam logic [AMT_W:0]   C_STEP  = (AMT_W+1)'(STEP);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_work;
  logic [3:0]         r_op;
  logic [AMT_W-1:0]   r_rem;
  logic               r_carry;

  logic               w_accept;
  logic [AMT_W:0]     w_rem_ext;
  logic [AMT_W:0]     w_k;
  logic [AMT_W-1:0]   w_k_lo;
  logic               w_last_step;
  logic [WIDTH-1:0]   w_sll;
  logic [WIDTH-1:0]   w_srl;
  logic [WIDTH-1:0]   w_sra;
  logic               w_c_sll;
  logic               w_c_srl;
  logic [WIDTH-1:0]   w_work_nxt;
  logic               w_carry_nxt;

  // ---------------- step datapath ----------------
  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_rem_ext   = {1'b0, r_rem};
  assign w_k         = (w_rem_ext < C_STEP) ? w_rem_ext : C_STEP;
  // rem <= WIDTH-1, so k always fits in AMT_W bits.
  assign w_k_lo      = w_k[AMT_W-1:0];
  assign w_last_step = (r_rem == w_k_lo);

  assign w_sll = r_work << w_k;
  assign w_srl = r_work >> w_k;
  assign w_sra = $signed(r_work) >>> w_k;

  // Carry is the last bit to leave the word: work[WIDTH-k] for left shifts,
  // work[k-1] for right shifts. Masking avoids a variable part-select.
  assign w_c_sll = |(r_work & (C_ONE << (C_WIDTH - w_k)));
  assign w_c_srl = |(r_work & (C_ONE << (w_k - 1'b1)));

`ifdef ITER_SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] w_rot;
  assign w_rot = (r_work << w_k) | (r_work >> (C_WIDTH - w_k));
`endif

  always_comb begin
    w_work_nxt  = w_sra;
    w_carry_nxt = w_c_srl;
    case (r_op)
      4'd8: begin
        w_work_nxt  = w_sll;
        w_carry_nxt = w_c_sll;
      end
`ifdef ITER_SHIFTER_ROTATE_EN
      4'd9: begin
        w_work_nxt  = w_rot;
        w_carry_nxt = 1'b0;
      end
`else
      4'd9: begin
        w_work_nxt  = w_sll;
        w_carry_nxt = w_c_sll;
      end
`endif
      4'd10: begin
        w_work_nxt  = w_srl;
        w_carry_nxt = w_c_srl;
      end
      default: begin
        w_work_nxt  = w_sra;
        w_carry_nxt = w_c_srl;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_op    <= '0;
      r_rem   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_work  <= data;
      r_op    <= op;
      r_rem   <= amt;
      r_carry <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_work  <= w_work_nxt;
      r_carry <= w_carry_nxt;
      r_rem   <= r_rem - w_k_lo;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    result      = '0;
    cond        = 4'b0000;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (amt != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_last_step) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        result    = r_work;
        cond      = {r_work[WIDTH-1], (r_work == '0), r_carry, 1'b0};
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule
